rx_packet_parser: RTL and testbench
===================================

# rx_packet_parser

Byte-level packet parser that sits directly downstream of the RS232 receiver. It consumes each received byte on the receiver's one-cycle completion strobe and assembles fixed 5-byte command packets (sync, address, data high, data low, checksum). Each packet is checked with an XOR checksum, and a valid packet is emitted as a single-cycle register-write strobe toward the register bank. Malformed packets and stalled packets are flagged and discarded.

## Interface
- TIMEOUT_CYCLES, 200000: maximum idle clock cycles allowed between bytes inside a packet. Valid range is 2 to 2^24.
- SYNC_BYTE, 8'hA5: packet start marker.
- clk_i  input  1  system clock. All logic is on the rising edge.
- rst_ni  input  1  reset. Synchronous and active-low.
- data_i  input  8  received byte from the RS232 receiver's parallel register. Valid only when valid_i is high.
- valid_i  input  1  one-cycle byte-available strobe from the receiver. Consecutive strobes are never closer than 2 cycles.
- addr_o  output  8  address of the last valid packet. Held until the next valid packet.
- wdata_o  output  16  data of the last valid packet, as {DATA_HI, DATA_LO}. Held until the next valid packet.
- wr_o  output  1  one-cycle pulse: addr_o and wdata_o have been updated.
- err_o  output  1  one-cycle pulse: checksum mismatch, packet dropped.
- to_o  output  1  one-cycle pulse: inter-byte timeout, packet dropped.
- busy_o  output  1  high while a packet is partially received (state other than IDLE).
- err_cnt_o  output  8  saturating count of err_o plus to_o events. Present only with the configuration macro.

## Operation
- States: IDLE, ADDR, DHI, DLO, CHK.
- IDLE:
  - valid_i with data_i == SYNC_BYTE: go to ADDR.
  - Any other byte: ignored, stay in IDLE.
- ADDR, DHI, DLO:
  - valid_i: capture data_i into an internal shadow register (addr_s, hi_s, lo_s), then advance to the next state.
  - A SYNC_BYTE value in these fields is ordinary data, not a restart.
- CHK, on valid_i:
  - Computed checksum = addr_s ^ hi_s ^ lo_s.
  - If data_i matches: load addr_o and wdata_o from the shadow registers and pulse wr_o.
  - Otherwise: pulse err_o; addr_o and wdata_o are unchanged.
  - Either way, go to IDLE.
- Timeout:
  - A cycle counter clears on every valid_i and whenever the state is IDLE.
  - In any non-IDLE state it increments once per cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no valid_i: pulse to_o and go to IDLE. Shadow registers are not cleared.
- Simultaneous valid_i and timeout expiry: the byte wins. It is processed normally, the counter clears, and there is no to_o.
- wr_o, err_o and to_o are mutually exclusive in any given cycle.
- Reset mid-packet: the state returns to IDLE and the partial packet is lost. There are no output pulses during or immediately after reset.

## Timing
- Reset values:
  - State IDLE, timeout counter 0, shadow registers 0.
  - addr_o = 0, wdata_o = 0, wr_o = 0, err_o = 0, to_o = 0, busy_o = 0, err_cnt_o = 0.
- All outputs are registered.
- wr_o / err_o assert exactly 1 cycle after the valid_i that carried the checksum byte. addr_o and wdata_o update on that same edge.
- busy_o rises 1 cycle after the valid_i carrying SYNC_BYTE, and falls on the same edge that raises wr_o, err_o or to_o.
- to_o asserts TIMEOUT_CYCLES cycles after the last accepted byte.
- A new SYNC_BYTE is accepted in the cycle immediately after returning to IDLE.

## Configuration
- Macro: RX_PARSER_ERR_CNT_EN.
- Defined: err_cnt_o is an 8-bit counter.
  - Increments on every err_o or to_o pulse, on the same edge as the pulse.
  - Saturates at 8'hFF.
  - Cleared only by reset.
- Undefined: the counter is not built and err_cnt_o is tied to 8'h00.

## Structure
- Shared package rx_parser_pkg holds:
  - the state encoding localparams (IDLE=0 … CHK=4, 3 bits);
  - the default SYNC_BYTE;
  - the packet length constant (5).
- One sub-module, rx_timeout_cnt:
  - Parameter TIMEOUT_CYCLES.
  - Counter width is $clog2(TIMEOUT_CYCLES).
  - Inputs clr_i and en_i; output expire_o is a one-cycle flag when the count reaches TIMEOUT_CYCLES-1.
- The top-level FSM instantiates rx_timeout_cnt and drives clr_i = valid_i | (state == IDLE).

## Test plan
- Good packet: bytes A5 12 34 56 70, spaced 10 cycles apart -> wr_o single pulse 1 cycle after the last byte; addr_o = 8'h12, wdata_o = 16'h3456; no err_o.
- Bad checksum: A5 12 34 56 71 -> err_o single pulse; wr_o stays 0; addr_o and wdata_o keep their previous values; err_cnt_o = 1 when the macro is defined, 0 when it is not.
- Leading garbage: 00 FF 5A, then A5 01 02 03 00 -> garbage ignored with busy_o low throughout; wr_o pulse with addr_o = 8'h01, wdata_o = 16'h0203.
- Timeout (TIMEOUT_CYCLES = 20): A5 12, then silence -> to_o pulse 20 cycles after byte 12; busy_o falls on the same edge. A following good packet is accepted normally.
- Boundary at expiry (TIMEOUT_CYCLES = 20): A5, then the next byte arrives on exactly the expiry cycle -> no to_o; the byte is accepted and the state reaches DHI.
- Reset mid-packet: A5 12 34, then rst_ni low for 1 cycle, then A5 AA BB CC DD -> only one wr_o (addr_o = 8'hAA, wdata_o = 16'hBBCC); no err_o and no to_o.

Source files
------------

// File: rtl/rx_packet_parser_pkg.sv
// rtl/rx_packet_parser_pkg.sv - shared state encoding, sync byte and checksum helper for rx_packet_parser
package rx_parser_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ADDR = 3'd1;
   localparam logic [2:0] ST_DHI  = 3'd2;
   localparam logic [2:0] ST_DLO  = 3'd3;
   localparam logic [2:0] ST_CHK  = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      ADDR = ST_ADDR,
      DHI  = ST_DHI,
      DLO  = ST_DLO,
      CHK  = ST_CHK
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int         PKT_LEN           = 5;

   // XOR of the three payload bytes; the sync byte is not covered
   function automatic logic [7:0] pkt_checksum(input logic [7:0] a, input logic [7:0] h,
                                               input logic [7:0] l);
      return a ^ h ^ l;
   endfunction

endpackage

// File: rtl/rx_packet_parser_if.sv
// rtl/rx_packet_parser_if.sv - byte input and register-write output bundle of rx_packet_parser
interface rx_packet_parser_if;

   logic [7:0]  data_i;
   logic        valid_i;
   logic [7:0]  addr_o;
   logic [15:0] wdata_o;
   logic        wr_o;
   logic        err_o;
   logic        to_o;
   logic        busy_o;
   logic [7:0]  err_cnt_o;

   modport master (
      output data_i, valid_i,
      input  addr_o, wdata_o, wr_o, err_o, to_o, busy_o, err_cnt_o
   );

   modport slave (
      input  data_i, valid_i,
      output addr_o, wdata_o, wr_o, err_o, to_o, busy_o, err_cnt_o
   );

endinterface

// File: rtl/rx_packet_parser_timeout_cnt.sv
// rtl/rx_packet_parser_timeout_cnt.sv - inter-byte idle cycle counter with one-cycle expiry flag
module rx_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_last;

   // Count idle cycles, parking at the last value; a clear in the expiry cycle suppresses the flag
   always_comb begin
      at_last  = (cnt_q == LAST);
      expire_o = en_i & ~clr_i & at_last;
      cnt_d    = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !at_last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rx_packet_parser.sv
// rtl/rx_packet_parser.sv - 5-byte command packet parser with XOR check; RX_PARSER_ERR_CNT_EN adds err_cnt_o
module rx_packet_parser
   import rx_parser_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 200000,
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
   input logic               clk_i,
   input logic               rst_ni,
   rx_packet_parser_if.slave bus
);

   state_t      state_q, state_d;
   logic [7:0]  addr_s_q, addr_s_d;
   logic [7:0]  hi_s_q, hi_s_d;
   logic [7:0]  lo_s_q, lo_s_d;
   logic [7:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        err_q, err_d;
   logic        to_q, to_d;
   logic        busy_q, busy_d;
   logic        tmo_clr, tmo_en, tmo_expire;

   assign tmo_en  = (state_q != IDLE);
   assign tmo_clr = bus.valid_i | (state_q == IDLE);

   rx_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (tmo_clr),
      .en_i    (tmo_en),
      .expire_o(tmo_expire)
   );

   // Packet FSM: capture fields, verify checksum, drop on stall
   always_comb begin
      state_d  = state_q;
      addr_s_d = addr_s_q;
      hi_s_d   = hi_s_q;
      lo_s_d   = lo_s_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wr_d     = 1'b0;
      err_d    = 1'b0;
      to_d     = 1'b0;
      unique case (state_q)
         IDLE: if (bus.valid_i && bus.data_i == SYNC_BYTE) state_d = ADDR;
         ADDR: if (bus.valid_i) begin
            addr_s_d = bus.data_i;
            state_d  = DHI;
         end
         DHI: if (bus.valid_i) begin
            hi_s_d  = bus.data_i;
            state_d = DLO;
         end
         DLO: if (bus.valid_i) begin
            lo_s_d  = bus.data_i;
            state_d = CHK;
         end
         CHK: if (bus.valid_i) begin
            if (bus.data_i == pkt_checksum(addr_s_q, hi_s_q, lo_s_q)) begin
               addr_d  = addr_s_q;
               wdata_d = {hi_s_q, lo_s_q};
               wr_d    = 1'b1;
            end else begin
               err_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Expiry is already gated by valid_i, so an arriving byte always wins
      if (tmo_expire) begin
         to_d    = 1'b1;
         state_d = IDLE;
      end
      busy_d = (state_d != IDLE);
   end

   // State, shadow and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         addr_s_q <= '0;
         hi_s_q   <= '0;
         lo_s_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_s_q <= addr_s_d;
         hi_s_q   <= hi_s_d;
         lo_s_q   <= lo_s_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         to_q     <= to_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.addr_o  = addr_q;
   assign bus.wdata_o = wdata_q;
   assign bus.wr_o    = wr_q;
   assign bus.err_o   = err_q;
   assign bus.to_o    = to_q;
   assign bus.busy_o  = busy_q;

`ifdef RX_PARSER_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating count of dropped packets, updated on the same edge as the pulse
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((err_d || to_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error counter register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.err_cnt_o = err_cnt_q;
`else
   assign bus.err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_rx_packet_parser.sv
// tb/tb_rx_packet_parser.sv - self-checking bench for rx_packet_parser
module tb_rx_packet_parser;

   localparam int T = 20;
`ifdef RX_PARSER_ERR_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   rx_packet_parser_if bus();

   rx_packet_parser #(
      .TIMEOUT_CYCLES(T),
      .SYNC_BYTE     (8'hA5)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int wr_seen, err_seen, to_seen;

   // reference model: the bytes of the packet in progress and idle cycles since the last byte
   logic [7:0]  pkt[$];
   int          idle;
   logic [7:0]  exp_addr, exp_cnt;
   logic [15:0] exp_wdata;
   logic        exp_wr, exp_err, exp_to, exp_busy;

   typedef struct {
      logic [39:0] bytes;
      bit          garbage;
      int          gap;
      logic        exp_wr;
      logic        exp_err;
      logic [7:0]  exp_addr;
      logic [15:0] exp_wdata;
      int          exp_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic v, input logic [7:0] d);
      logic [7:0] cs;
      if (!rst_n) begin
         pkt.delete();
         idle      = 0;
         exp_addr  = 8'h00;
         exp_wdata = 16'h0000;
         exp_wr    = 1'b0;
         exp_err   = 1'b0;
         exp_to    = 1'b0;
         exp_busy  = 1'b0;
         exp_cnt   = 8'h00;
         return;
      end
      exp_wr  = 1'b0;
      exp_err = 1'b0;
      exp_to  = 1'b0;
      if (v) begin
         idle = 0;
         if (pkt.size() != 0 || d == 8'hA5) pkt.push_back(d);
         if (pkt.size() == 5) begin
            cs = pkt[1] ^ pkt[2] ^ pkt[3];
            if (cs == pkt[4]) begin
               exp_wr    = 1'b1;
               exp_addr  = pkt[1];
               exp_wdata = {pkt[2], pkt[3]};
            end else begin
               exp_err = 1'b1;
            end
            pkt.delete();
         end
      end else if (pkt.size() != 0) begin
         idle++;
         if (idle >= T) begin
            exp_to = 1'b1;
            pkt.delete();
         end
      end
      if ((exp_err || exp_to) && CNT_ON != 0 && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      exp_busy = (pkt.size() != 0);
   endtask

   // one clock: drive inputs, advance model, sample 1 time unit after the edge
   task automatic step(input logic v, input logic [7:0] d);
      bus.valid_i = v;
      bus.data_i  = d;
      model_step(v, d);
      @(posedge clk);
      #1;
      chk("wr_o", bus.wr_o, exp_wr);
      chk("err_o", bus.err_o, exp_err);
      chk("to_o", bus.to_o, exp_to);
      chk("busy_o", bus.busy_o, exp_busy);
      chk("addr_o", bus.addr_o, exp_addr);
      chk("wdata_o", bus.wdata_o, exp_wdata);
      chk("err_cnt_o", bus.err_cnt_o, exp_cnt);
      if (bus.wr_o) wr_seen++;
      if (bus.err_o) err_seen++;
      if (bus.to_o) to_seen++;
      bus.valid_i = 1'b0;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
   endtask

   task automatic send_pkt(input logic [39:0] b, input int gap);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, b[39-8*k -: 8]);
         if (k < 4) idle_n(gap);
      end
   endtask

   initial begin
      logic [7:0] garb[3];
      logic [7:0] a, h, l, cs;
      int         got, r, g, nb;

      garb = '{8'h00, 8'hFF, 8'h5A};
      vecs[0] = '{40'hA5_12_34_56_70, 1'b0, 9, 1'b1, 1'b0, 8'h12, 16'h3456, 0};
      vecs[1] = '{40'hA5_12_34_56_71, 1'b0, 3, 1'b0, 1'b1, 8'h12, 16'h3456, 1};
      vecs[2] = '{40'hA5_01_02_03_00, 1'b1, 2, 1'b1, 1'b0, 8'h01, 16'h0203, 1};
      vecs[3] = '{40'hA5_A5_A5_A5_A5, 1'b0, 1, 1'b1, 1'b0, 8'hA5, 16'hA5A5, 1};
      vecs[4] = '{40'hA5_FF_00_FF_00, 1'b0, 5, 1'b1, 1'b0, 8'hFF, 16'h00FF, 1};
      vecs[5] = '{40'hA5_00_00_00_01, 1'b0, 1, 1'b0, 1'b1, 8'hFF, 16'h00FF, 2};

      wr_seen = 0; err_seen = 0; to_seen = 0;
      rst_n = 1'b0;
      bus.valid_i = 1'b0;
      bus.data_i = 8'h00;
      step(1'b0, 8'h00);
      step(1'b1, 8'hA5);
      chk("reset_busy", bus.busy_o, 1'b0);
      rst_n = 1'b1;

      // table-driven packets
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].garbage) begin
            for (int j = 0; j < 3; j++) begin
               step(1'b1, garb[j]);
               chk("garbage_busy", bus.busy_o, 1'b0);
               step(1'b0, 8'h00);
               chk("garbage_busy", bus.busy_o, 1'b0);
            end
         end
         send_pkt(vecs[i].bytes, vecs[i].gap);
         chk("vec_wr", bus.wr_o, vecs[i].exp_wr);
         chk("vec_err", bus.err_o, vecs[i].exp_err);
         chk("vec_addr", bus.addr_o, vecs[i].exp_addr);
         chk("vec_wdata", bus.wdata_o, vecs[i].exp_wdata);
         chk("vec_err_cnt", bus.err_cnt_o, vecs[i].exp_cnt * CNT_ON);
         idle_n(3);
      end

      // timeout after the address byte, then an immediate new packet
      step(1'b1, 8'hA5);
      idle_n(2);
      step(1'b1, 8'h12);
      got = 0;
      for (int c = 1; c <= 3 * T; c++) begin
         step(1'b0, 8'h00);
         if (bus.to_o) begin
            got = c;
            chk("to_busy_fall", bus.busy_o, 1'b0);
            break;
         end
      end
      chk("to_latency", got, T);
      send_pkt(40'hA5_01_02_03_00, 2);
      chk("after_to_wr", bus.wr_o, 1'b1);
      chk("after_to_addr", bus.addr_o, 8'h01);
      idle_n(2);

      // byte lands in the expiry cycle
      step(1'b1, 8'hA5);
      idle_n(T - 1);
      step(1'b1, 8'h12);
      chk("expiry_no_to", bus.to_o, 1'b0);
      chk("expiry_busy", bus.busy_o, 1'b1);
      idle_n(1); step(1'b1, 8'h34);
      idle_n(1); step(1'b1, 8'h56);
      idle_n(1); step(1'b1, 8'h70);
      chk("expiry_wr", bus.wr_o, 1'b1);
      chk("expiry_wdata", bus.wdata_o, 16'h3456);
      idle_n(2);

      // reset in the middle of a packet
      wr_seen = 0; err_seen = 0; to_seen = 0;
      step(1'b1, 8'hA5); idle_n(1);
      step(1'b1, 8'h12); idle_n(1);
      step(1'b1, 8'h34); idle_n(1);
      rst_n = 1'b0;
      step(1'b0, 8'h00);
      rst_n = 1'b1;
      chk("rst_busy", bus.busy_o, 1'b0);
      send_pkt(40'hA5_AA_BB_CC_DD, 1);
      idle_n(2);
      chk("rst_wr_count", wr_seen, 1);
      chk("rst_err_count", err_seen, 0);
      chk("rst_to_count", to_seen, 0);
      chk("rst_addr", bus.addr_o, 8'hAA);
      chk("rst_wdata", bus.wdata_o, 16'hBBCC);

      // randomized byte stream against the model
      for (int p = 0; p < 60; p++) begin
         r  = int'($urandom_range(0, 9));
         a  = 8'($urandom);
         h  = 8'($urandom);
         l  = 8'($urandom);
         cs = a ^ h ^ l;
         if (r < 2) cs = cs ^ (8'h01 << $urandom_range(0, 7));
         nb = (r == 2) ? 1 : (r == 3) ? int'($urandom_range(2, 4)) : 5;
         for (int k = 0; k < nb; k++) begin
            case (k)
               0: step(1'b1, (r == 2) ? 8'($urandom) : 8'hA5);
               1: step(1'b1, a);
               2: step(1'b1, h);
               3: step(1'b1, l);
               default: step(1'b1, cs);
            endcase
            g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 3, T + 4))
                                            : int'($urandom_range(1, 6));
            idle_n(g);
         end
      end
      idle_n(T + 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
